clause_bank_evaluator: RTL and testbench
========================================

Name: clause_bank_evaluator

Overview:
- Parametrised clause store and evaluator for the SAT solver datapath.
- Loads CNF clauses as alternating positive-mask and negative-mask literal words, then checks a full assignment against every stored clause, one clause per cycle.
- Supersedes the fixed-width loading inside top: clause depth is configurable, and it adds overflow/malformed detection plus a stop-on-first-failure mode.
- Sits between the clause load interface and the solver search engine.

Parameters:
- NUM_LIT, default number_literal (30), literal count and word width.
- MAX_CLAUSES, default 64, clause storage depth.
- CW, default $clog2(MAX_CLAUSES+1), width of clause counters and indices.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  level; while high, one literal word is accepted per cycle.
- lit_in  in  NUM_LIT  literal word; bit k is literal k.
- clear  in  1  pulse; empties the bank.
- eval_start  in  1  pulse; starts evaluation of assign_in.
- stop_on_fail  in  1  mode: 1 ends evaluation at the first unsatisfied clause.
- assign_in  in  NUM_LIT  assignment (1=true); sampled on the eval_start cycle.
- busy  out  1  high in LOAD_POS, LOAD_NEG and EVAL.
- clause_count  out  CW  number of complete clauses stored.
- overflow  out  1  sticky; a clause arrived when the bank was full.
- malformed  out  1  sticky; load dropped after a positive word.
- done  out  1  one-cycle pulse at the end of evaluation.
- all_sat  out  1  valid with done.
- fail_idx  out  CW  index of the first unsatisfied clause; MAX_CLAUSES if none.
- sat_count  out  CW  count of satisfied clauses evaluated.

Behaviour:
- Reset (reset=0, asynchronous) sets state IDLE and zeroes all outputs, clause_count and flags. fail_idx resets to MAX_CLAUSES. Memory contents are don't-care.
- States: IDLE, LOAD_POS, LOAD_NEG, EVAL.
- IDLE with load=1: capture lit_in as the positive mask of the clause at index clause_count, then go to LOAD_NEG. The capture happens in that same cycle.
- LOAD_NEG with load=1: capture lit_in as the negative mask, commit the clause, increment clause_count, go to LOAD_POS.
- LOAD_POS with load=1: capture the positive mask, go to LOAD_NEG.
- load=0 in LOAD_POS: return to IDLE.
- load=0 in LOAD_NEG: discard the half clause, set malformed, return to IDLE.
- Full bank: when clause_count==MAX_CLAUSES, words are not written and the count holds. Any pair completed while full sets overflow.
- A literal set in both masks of one clause makes that clause a tautology; store it unchanged.
- clear: honoured only in IDLE. It zeroes clause_count, overflow and malformed. If clear and load are both high, clear wins for that cycle.
- eval_start: honoured only in IDLE and when load=0 and clear=0. It is ignored in every other state (no queuing).
  - Latch assign_in, zero sat_count, set fail_idx=MAX_CLAUSES, set index=0, go to EVAL.
- EVAL, each cycle for clause j: sat_j = |(pos_j & a) | |(neg_j & ~a).
  - An empty clause (both masks zero) is unsatisfied.
  - If sat_j, increment sat_count. Otherwise, set fail_idx=j if this is the first failure.
- Evaluation ends after the last stored clause, or after the first failure when stop_on_fail=1. stop_on_fail is sampled on the eval_start cycle.
- The end cycle pulses done with all_sat = (no failure), then returns to IDLE.
- Latency: an eval_start accepted at edge T gives done at edge T+N+1 for N clauses. With stop_on_fail=1 and first failure at j, done comes at T+j+2.
- N=0: done at T+1 with all_sat=1, sat_count=0.
- load, clear and lit_in are ignored during EVAL.
- all_sat, fail_idx and sat_count hold until the next accepted eval_start or reset.
- Reset mid-load or mid-eval aborts immediately; no done pulse is produced.

Decomposition:
- Package common holds number_literal, a clause_t struct {pos, neg} of number_literal bits each, and the state enum typedef.
- Sub-module clause_sat_check: combinational, takes clause_t and the assignment, outputs sat. It is reused by the solver BCP unit.
- Storage is a plain register array of clause_t inside the block.

Test Plan (NUM_LIT=4, MAX_CLAUSES=4):
- Load pairs (1000,0000), (0000,0100), (0011,0000); eval assign 1001 -> clause_count=3, done at T+4, all_sat=1, sat_count=3, fail_idx=4.
- Same bank, assign 0101, stop_on_fail=0 -> all_sat=0, fail_idx=0, sat_count=1, done at T+4.
- Same bank, assign 0101, stop_on_fail=1 -> done at T+2, fail_idx=0, sat_count=0.
- Load 5 pairs -> clause_count=4, overflow=1. Then load 1 word and drop load -> malformed=1, clause_count=4. Then clear -> all three return to 0.
- Empty bank eval -> done at T+1, all_sat=1. Stored clause (0000,0000) -> all_sat=0, fail_idx=0.
- Assert reset low during EVAL -> busy=0 and done=0 immediately, with no done pulse later. eval_start during load -> ignored.

Source files
------------

// File: rtl/clause_bank_evaluator_pkg.sv
// Shared SAT datapath types: literal width, clause record and bank FSM states.
package common;
  localparam int number_literal = 30;

  typedef struct packed {
    logic [number_literal-1:0] pos;
    logic [number_literal-1:0] neg;
  } clause_t;

  typedef enum logic [1:0] {IDLE, LOAD_POS, LOAD_NEG, EVAL} state_e;
endpackage

// File: rtl/clause_bank_evaluator_sat_check.sv
// Combinational clause check: satisfied if any positive literal is true or any negative literal is false.
module clause_sat_check
  import common::*;
(
  input  clause_t                   cl,
  input  logic [number_literal-1:0] a,
  output logic                      sat
);
  // An empty clause has no literal that can fire, so it falls out as unsatisfied.
  assign sat = |(cl.pos & a) | |(cl.neg & ~a);
endmodule

// File: rtl/clause_bank_evaluator.sv
// Clause store loaded as pos/neg word pairs; evaluates one stored clause per cycle against an assignment.
module clause_bank_evaluator
  import common::*;
#(
  parameter int NUM_LIT     = number_literal,
  parameter int MAX_CLAUSES = 64,
  parameter int CW          = $clog2(MAX_CLAUSES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [NUM_LIT-1:0] lit_in,
  input  logic               clear,
  input  logic               eval_start,
  input  logic               stop_on_fail,
  input  logic [NUM_LIT-1:0] assign_in,
  output logic               busy,
  output logic [CW-1:0]      clause_count,
  output logic               overflow,
  output logic               malformed,
  output logic               done,
  output logic               all_sat,
  output logic [CW-1:0]      fail_idx,
  output logic [CW-1:0]      sat_count
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CLAUSES);

  state_e                    state_q, state_d;
  clause_t                   mem [1<<CW];
  logic [CW-1:0]             idx;
  logic [NUM_LIT-1:0]        a_q;
  logic                      stop_q;
  logic [number_literal-1:0] a_ext;
  clause_t                   cur;
  logic                      cur_sat;
  logic                      full, no_fail;
  logic                      wr_pos, wr_neg, set_mal, do_clear, do_start, do_eval, do_end;

  assign full    = (clause_count == MAXC);
  assign no_fail = (fail_idx == MAXC);
  assign busy    = (state_q != IDLE);
  assign a_ext   = number_literal'(a_q);
  assign cur     = mem[idx];

  clause_sat_check u_chk (.cl(cur), .a(a_ext), .sat(cur_sat));

  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    wr_pos   = 1'b0;
    wr_neg   = 1'b0;
    set_mal  = 1'b0;
    do_clear = 1'b0;
    do_start = 1'b0;
    do_eval  = 1'b0;
    do_end   = 1'b0;
    case (state_q)
      IDLE:
        if (clear) do_clear = 1'b1;
        else if (load) begin
          wr_pos  = 1'b1;
          state_d = LOAD_NEG;
        end else if (eval_start) begin
          do_start = 1'b1;
          state_d  = EVAL;
        end
      LOAD_POS:
        if (load) begin
          wr_pos  = 1'b1;
          state_d = LOAD_NEG;
        end else state_d = IDLE;
      LOAD_NEG:
        if (load) begin
          wr_neg  = 1'b1;
          state_d = LOAD_POS;
        end else begin
          set_mal = 1'b1;
          state_d = IDLE;
        end
      EVAL:
        // The end cycle evaluates nothing; it only publishes the result.
        if (idx == clause_count || (stop_q && !no_fail)) begin
          do_end  = 1'b1;
          state_d = IDLE;
        end else do_eval = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Half clauses land in the slot at clause_count; the count only advances on commit.
  always_ff @(posedge clock) begin
    if (wr_pos && !full) mem[clause_count].pos <= number_literal'(lit_in);
    if (wr_neg && !full) mem[clause_count].neg <= number_literal'(lit_in);
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      clause_count <= '0;
      overflow     <= 1'b0;
      malformed    <= 1'b0;
      done         <= 1'b0;
      all_sat      <= 1'b0;
      fail_idx     <= MAXC;
      sat_count    <= '0;
      idx          <= '0;
      a_q          <= '0;
      stop_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_clear) begin
        clause_count <= '0;
        overflow     <= 1'b0;
        malformed    <= 1'b0;
      end
      if (wr_neg) begin
        if (full) overflow <= 1'b1;
        else      clause_count <= clause_count + 1'b1;
      end
      if (set_mal) malformed <= 1'b1;
      if (do_start) begin
        a_q       <= assign_in;
        stop_q    <= stop_on_fail;
        sat_count <= '0;
        fail_idx  <= MAXC;
        idx       <= '0;
        all_sat   <= 1'b0;
      end
      if (do_eval) begin
        idx <= idx + 1'b1;
        if (cur_sat)      sat_count <= sat_count + 1'b1;
        else if (no_fail) fail_idx  <= idx;
      end
      if (do_end) begin
        done    <= 1'b1;
        all_sat <= no_fail;
      end
    end
endmodule

// File: tb/tb_clause_bank_evaluator.sv
// Bench for clause_bank_evaluator: directed table, corner sequences and randomized banks vs a clause-list model.
module tb_clause_bank_evaluator;
  localparam int NL = 4;
  localparam int MC = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0, clear = 1'b0, eval_start = 1'b0, stop_on_fail = 1'b0;
  logic [NL-1:0] lit_in = '0, assign_in = '0;
  logic          busy, overflow, malformed, done, all_sat;
  logic [CW-1:0] clause_count, fail_idx, sat_count;

  clause_bank_evaluator #(.NUM_LIT(NL), .MAX_CLAUSES(MC), .CW(CW)) dut (
    .clock(clock), .reset(reset), .load(load), .lit_in(lit_in), .clear(clear),
    .eval_start(eval_start), .stop_on_fail(stop_on_fail), .assign_in(assign_in),
    .busy(busy), .clause_count(clause_count), .overflow(overflow), .malformed(malformed),
    .done(done), .all_sat(all_sat), .fail_idx(fail_idx), .sat_count(sat_count));

  always #5 clock = ~clock;

  int tests = 0, fails = 0, done_cnt = 0;
  always @(negedge clock) if (done === 1'b1) done_cnt++;

  // Model: list of stored clauses plus sticky flags.
  logic [NL-1:0] mpos[$], mneg[$];
  bit            movf = 0, mmal = 0;
  logic [NL-1:0] wbuf [16];

  typedef struct {
    logic [NL-1:0] a;
    bit            stop;
    int            asat, fidx, scnt, lat;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mpos.delete(); mneg.delete(); movf = 0; mmal = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic load_seq(input int n, input bit with_start);
    for (int i = 0; i < n; i++) begin
      lit_in = wbuf[i]; load = 1'b1; eval_start = with_start;
      @(negedge clock);
    end
    load = 1'b0; eval_start = 1'b0;
    if (n > 0) @(negedge clock);
    for (int p = 0; p + 1 < n; p += 2)
      if (mpos.size() < MC) begin mpos.push_back(wbuf[p]); mneg.push_back(wbuf[p+1]); end
      else movf = 1;
    if (n % 2 == 1) mmal = 1;
  endtask

  task automatic model_eval(input logic [NL-1:0] a, input bit stop,
                            output int asat, output int fidx, output int scnt, output int lat);
    bit s;
    fidx = MC; scnt = 0;
    for (int j = 0; j < mpos.size(); j++) begin
      s = 0;
      for (int k = 0; k < NL; k++)
        if ((mpos[j][k] && a[k]) || (mneg[j][k] && !a[k])) s = 1;
      if (s) scnt++;
      else if (fidx == MC) fidx = j;
      if (!s && stop) break;
    end
    asat = (fidx == MC);
    lat  = (stop && fidx != MC) ? fidx + 2 : mpos.size() + 1;
  endtask

  task automatic run_eval(input logic [NL-1:0] a, input bit stop, output int lat);
    assign_in = a; stop_on_fail = stop; eval_start = 1'b1;
    @(posedge clock); #1 eval_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k; break; end
    end
    @(negedge clock);
  endtask

  task automatic eval_chk(input string name, input logic [NL-1:0] a, input bit stop,
                          input int easat, input int efidx, input int escnt, input int elat);
    int lat;
    run_eval(a, stop, lat);
    chk({name, " latency"}, lat, elat);
    chk({name, " all_sat"}, all_sat, easat);
    chk({name, " fail_idx"}, fail_idx, efidx);
    chk({name, " sat_count"}, sat_count, escnt);
  endtask

  task automatic eval_model_chk(input string name, input logic [NL-1:0] a, input bit stop);
    int ea, ef, es, el;
    model_eval(a, stop, ea, ef, es, el);
    eval_chk(name, a, stop, ea, ef, es, el);
  endtask

  task automatic flags_chk(input string name);
    chk({name, " clause_count"}, clause_count, mpos.size());
    chk({name, " overflow"}, overflow, movf);
    chk({name, " malformed"}, malformed, mmal);
  endtask

  initial begin
    int snap, nw;
    tbl[0] = '{4'b1001, 1'b0, 1, 4, 3, 4};
    tbl[1] = '{4'b0101, 1'b0, 0, 0, 1, 4};
    tbl[2] = '{4'b0101, 1'b1, 0, 0, 0, 2};
    tbl[3] = '{4'b1100, 1'b0, 0, 1, 1, 4};
    tbl[4] = '{4'b1100, 1'b1, 0, 1, 1, 3};
    tbl[5] = '{4'b0000, 1'b0, 0, 0, 1, 4};

    repeat (2) @(negedge clock);
    chk("rst busy", busy, 0);
    chk("rst clause_count", clause_count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst malformed", malformed, 0);
    chk("rst done", done, 0);
    chk("rst all_sat", all_sat, 0);
    chk("rst fail_idx", fail_idx, MC);
    chk("rst sat_count", sat_count, 0);
    reset = 1'b1;
    @(negedge clock);

    // Directed bank: (1000,0000) (0000,0100) (0011,0000)
    wbuf[0] = 4'b1000; wbuf[1] = 4'b0000; wbuf[2] = 4'b0000;
    wbuf[3] = 4'b0100; wbuf[4] = 4'b0011; wbuf[5] = 4'b0000;
    load_seq(6, 1'b0);
    chk("bank clause_count", clause_count, 3);
    chk("bank busy", busy, 0);
    for (int i = 0; i < 6; i++)
      eval_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].stop,
               tbl[i].asat, tbl[i].fidx, tbl[i].scnt, tbl[i].lat);

    // Overflow, malformed, clear
    do_clear();
    for (int i = 0; i < 10; i++) wbuf[i] = 4'(i + 1);
    load_seq(10, 1'b0);
    chk("ovf clause_count", clause_count, 4);
    chk("ovf overflow", overflow, 1);
    chk("ovf malformed", malformed, 0);
    wbuf[0] = 4'b1111;
    load_seq(1, 1'b0);
    chk("mal malformed", malformed, 1);
    chk("mal clause_count", clause_count, 4);
    chk("mal overflow", overflow, 1);
    do_clear();
    chk("clr clause_count", clause_count, 0);
    chk("clr overflow", overflow, 0);
    chk("clr malformed", malformed, 0);

    // Empty bank, then a single empty clause
    eval_chk("empty bank", 4'b1010, 1'b0, 1, MC, 0, 1);
    wbuf[0] = 4'b0000; wbuf[1] = 4'b0000;
    load_seq(2, 1'b0);
    eval_chk("empty clause", 4'b1111, 1'b0, 0, 0, 0, 2);

    // Tautology clause stored as-is: always satisfied
    do_clear();
    wbuf[0] = 4'b0010; wbuf[1] = 4'b0010;
    load_seq(2, 1'b0);
    eval_chk("taut a0", 4'b0000, 1'b1, 1, MC, 1, 2);
    eval_chk("taut a1", 4'b0010, 1'b1, 1, MC, 1, 2);

    // eval_start held during load is ignored
    do_clear();
    snap = done_cnt;
    wbuf[0] = 4'b0001; wbuf[1] = 4'b0000; wbuf[2] = 4'b0000; wbuf[3] = 4'b0001;
    load_seq(4, 1'b1);
    repeat (4) @(negedge clock);
    chk("start-during-load done pulses", done_cnt - snap, 0);
    chk("start-during-load clause_count", clause_count, 2);
    chk("start-during-load busy", busy, 0);

    // Reset asserted mid-evaluation
    wbuf[0] = 4'b0001; wbuf[1] = 4'b0000; wbuf[2] = 4'b0010; wbuf[3] = 4'b0000;
    load_seq(4, 1'b0);
    chk("pre-rst clause_count", clause_count, 4);
    assign_in = 4'b0000; stop_on_fail = 1'b0; eval_start = 1'b1;
    @(posedge clock); #1 eval_start = 1'b0;
    @(posedge clock); #1;
    chk("mid-eval busy", busy, 1);
    snap = done_cnt;
    reset = 1'b0;
    #1;
    chk("rst-eval busy", busy, 0);
    chk("rst-eval done", done, 0);
    chk("rst-eval clause_count", clause_count, 0);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    repeat (10) @(negedge clock);
    chk("rst-eval no late done", done_cnt - snap, 0);

    // Randomized banks against the model
    for (int it = 0; it < 30; it++) begin
      do_clear();
      nw = $urandom_range(0, 11);
      for (int i = 0; i < nw; i++) wbuf[i] = 4'($urandom_range(0, 15));
      load_seq(nw, 1'b0);
      flags_chk($sformatf("rnd%0d", it));
      for (int e = 0; e < 3; e++)
        eval_model_chk($sformatf("rnd%0d.%0d", it, e), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
